axi_ddr_rr_arbiter: RTL
=======================

# axi_ddr_rr_arbiter

Round-robin AXI4 arbiter that lets `M_NUM` AXI masters share the single DDR3 AXI slave port, for example the UDP command path, JTAG bridge and future DMA engines. Write and read directions are arbitrated independently, and each direction has one outstanding transaction at a time. The block sits between the master-side interconnect and the DDR3 controller's AXI port, in the DDR controller's clock domain. Responses are routed back using the registered grant, so no ID remapping is needed.

## Interface
Parameters:
- `M_NUM`, 2: number of masters, 2..4.
- `ADDR_W`, 32: AXI address width.
- `DATA_W`, 32: AXI data width.
- `ID_W`, 4: AXI ID width, passed through unchanged.

Ports:
- `clk` in 1: single clock for the whole block.
- `rstn` in 1: asynchronous, active-low reset.
- `s_aw{id,addr,len,burst,valid}` in, width M_NUM×{ID_W,ADDR_W,8,2,1}: write-address channel from each master; `s_awready` out M_NUM.
- `s_w{data,strb,last,valid}` in, width M_NUM×{DATA_W,DATA_W/8,1,1}: write-data channel; `s_wready` out M_NUM.
- `s_b{id,resp,valid}` out, width M_NUM×{ID_W,2,1}: write response; `s_bready` in M_NUM.
- `s_ar{id,addr,len,burst,valid}` in, width M_NUM×{ID_W,ADDR_W,8,2,1}: read-address channel; `s_arready` out M_NUM.
- `s_r{id,data,resp,last,valid}` out, width M_NUM×{ID_W,DATA_W,2,1,1}: read data; `s_rready` in M_NUM.
- `m_*`: the same five channels towards DDR with single-master widths and mirrored directions.
- `wr_grant` out M_NUM: one-hot write owner, 0 when idle.
- `rd_grant` out M_NUM: one-hot read owner, 0 when idle.

## Operation
Write FSM states and transitions:
- `W_IDLE`: when any `s_awvalid` is high, pick the winner round-robin starting at `wr_ptr+1`, register the grant and go to `W_ADDR`.
- `W_ADDR`: drive `m_aw*` from the granted master and connect `s_awready[g]` to `m_awready`. On the AW handshake, go to `W_DATA`.
- `W_DATA`: route the W channel from the granted master. On a handshake with `wlast` set, go to `W_RESP`. Transfer ends on `wlast` only; `len` is not counted.
- `W_RESP`: route `m_b*` to the granted master only. On the B handshake, set `wr_ptr` to the grant, clear the grant and return to `W_IDLE`.

Read FSM, which runs independently and concurrently:
- `R_IDLE` → `R_ADDR` → `R_DATA` → `R_IDLE`.
- `R_DATA` exits on a handshake with `rvalid & rready & rlast`, then sets `rd_ptr`.

Routing rules:
- Non-granted masters see ready=0 and valid=0 on every channel.
- A master may hold AW and AR simultaneously. Each direction grants it independently.
- Each direction has its own pointer: `wr_ptr` and `rd_ptr`, each `$clog2(M_NUM)` bits. Pointer increments wrap modulo M_NUM.
- Requests arriving while a direction is busy wait, with no loss.
- A request must be held until it is granted, per AXI. Withdrawing it is unsupported: the grant registered in IDLE stays until the transaction completes.

## Timing
- Reset values:
  - FSMs go to IDLE; `wr_ptr` and `rd_ptr` are set to M_NUM-1, so master 0 wins first.
  - `wr_grant` and `rd_grant` are 0.
  - All `m_*valid`, `m_bready`, `m_rready`, `s_*ready` and `s_*valid` outputs are 0.
  - Data and ID outputs are 0.
- Arbitration latency:
  - `s_awvalid` seen in IDLE at cycle 0 → grant registered at the edge ending cycle 0 → `m_awvalid` asserted in cycle 1.
  - The read direction has the same latency.
- Throughput:
  - The FSM leaves ADDR, DATA and RESP in the cycle after the respective handshake; no bubbles occur inside W/R bursts.
  - After a completed transaction there is one IDLE cycle before the next grant.
- Data paths are combinational muxes selected by the registered grant; there is no added latency through the block.
- Reset mid-transaction aborts asynchronously:
  - All FSMs go to IDLE, outputs drop to their reset values and pointers reload.
  - The DDR slave shares the same reset domain.
- Simultaneous requests from all masters in IDLE: exactly one bit of the grant is set.

## Structure
- Shared package `axi_arb_pkg` contains:
  - The FSM state enums `wr_state_t` {W_IDLE, W_ADDR, W_DATA, W_RESP} and `rd_state_t` {R_IDLE, R_ADDR, R_DATA}.
  - Encodings for the AXI response codes (OKAY/SLVERR) and burst types.
- Sub-module `rr_arbiter`:
  - Parameterised by M_NUM.
  - Inputs: request vector, pointer and a `load` strobe.
  - Outputs: a one-hot grant and the grant index.
  - Instantiated twice, once for write and once for read.

## Test plan
- Single master 0 writes `len=3` bursts of 0x1234_5678.. to 0x0101_0101:
  - `m_awvalid` rises 1 cycle after `s_awvalid`.
  - 4 beats pass unchanged.
  - `s_bvalid[0]` is set; `wr_grant` returns to 0.
- Masters 0 and 1 assert `s_awvalid` in the same cycle after reset:
  - Master 0 is served first, then master 1.
  - Repeated simultaneous requests alternate 0,1,0,1.
- Concurrent traffic: master 1 reads `len=5` from 0x0000_00F0 while master 0 writes:
  - Both complete.
  - `wr_grant`=01 and `rd_grant`=10 overlap.
  - No cross-routing of R or B.
- Backpressure: DDR holds `m_wready`/`m_rready` low on random cycles:
  - No beat is lost or duplicated.
  - Non-granted `s_wready` stays 0 throughout.
- Error response: DDR returns `bresp`=2'b10:
  - Only the granted master sees `bresp`=2'b10 with its original `bid`.
- `rstn` is pulsed during a W_DATA beat:
  - All outputs go 0 immediately.
  - After release, master 0 is granted first again.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types for the DDR3 AXI round-robin arbiter.
// FSM encodings, AXI response/burst codes, pointer width helper.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_ddr_rr_arbiter_rr.sv
// Combinational round-robin pick, search starts at ptr+1.
// Grant is forced to zero unless load is high.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int M_NUM = 2,
  parameter int PW    = ptr_w(M_NUM)
)(
  input  logic [M_NUM-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  input  logic             i_load,
  output logic [M_NUM-1:0] o_grant,
  output logic [PW-1:0]    o_idx
);

  logic [PW-1:0]    w_idx;
  logic             w_hit;
  logic [M_NUM-1:0] w_oh;

  // scan from farthest to nearest so the nearest requester wins
  always_comb begin
    int c;
    w_idx = i_ptr;
    w_hit = 1'b0;
    for (int k = M_NUM; k >= 1; k--) begin
      c = (int'(i_ptr) + k) % M_NUM;
      if (i_req[c]) begin
        w_idx = PW'(c);
        w_hit = 1'b1;
      end
    end
  end

  // one-hot expansion of the winning index
  always_comb begin
    w_oh        = '0;
    w_oh[w_idx] = 1'b1;
  end

  assign o_grant = (i_load && w_hit) ? w_oh : '0;
  assign o_idx   = w_idx;

endmodule

// File: rtl/axi_ddr_rr_arbiter.sv
// M_NUM AXI masters sharing one DDR3 AXI slave port.
// Independent write/read round-robin, one outstanding per direction.
module axi_ddr_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int M_NUM  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
)(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [M_NUM*ID_W-1:0]    s_awid,
  input  logic [M_NUM*ADDR_W-1:0]  s_awaddr,
  input  logic [M_NUM*8-1:0]       s_awlen,
  input  logic [M_NUM*2-1:0]       s_awburst,
  input  logic [M_NUM-1:0]         s_awvalid,
  output logic [M_NUM-1:0]         s_awready,
  input  logic [M_NUM*DATA_W-1:0]  s_wdata,
  input  logic [M_NUM*DATA_W/8-1:0] s_wstrb,
  input  logic [M_NUM-1:0]         s_wlast,
  input  logic [M_NUM-1:0]         s_wvalid,
  output logic [M_NUM-1:0]         s_wready,
  output logic [M_NUM*ID_W-1:0]    s_bid,
  output logic [M_NUM*2-1:0]       s_bresp,
  output logic [M_NUM-1:0]         s_bvalid,
  input  logic [M_NUM-1:0]         s_bready,
  input  logic [M_NUM*ID_W-1:0]    s_arid,
  input  logic [M_NUM*ADDR_W-1:0]  s_araddr,
  input  logic [M_NUM*8-1:0]       s_arlen,
  input  logic [M_NUM*2-1:0]       s_arburst,
  input  logic [M_NUM-1:0]         s_arvalid,
  output logic [M_NUM-1:0]         s_arready,
  output logic [M_NUM*ID_W-1:0]    s_rid,
  output logic [M_NUM*DATA_W-1:0]  s_rdata,
  output logic [M_NUM*2-1:0]       s_rresp,
  output logic [M_NUM-1:0]         s_rlast,
  output logic [M_NUM-1:0]         s_rvalid,
  input  logic [M_NUM-1:0]         s_rready,
  output logic [ID_W-1:0]          m_awid,
  output logic [ADDR_W-1:0]        m_awaddr,
  output logic [7:0]               m_awlen,
  output logic [1:0]               m_awburst,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_wstrb,
  output logic                     m_wlast,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [ID_W-1:0]          m_bid,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic [ID_W-1:0]          m_arid,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [7:0]               m_arlen,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [ID_W-1:0]          m_rid,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output logic [M_NUM-1:0]         wr_grant,
  output logic [M_NUM-1:0]         rd_grant
);

  localparam int PW = ptr_w(M_NUM);
  localparam int SW = DATA_W / 8;

  wr_state_t        r_wst, w_wst_nxt;
  rd_state_t        r_rst, w_rst_nxt;
  logic [M_NUM-1:0] r_wgnt, r_rgnt;
  logic [PW-1:0]    r_widx, r_ridx;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [M_NUM-1:0] w_wgnt_arb, w_rgnt_arb;
  logic [PW-1:0]    w_widx_arb, w_ridx_arb;
  logic             w_wload, w_rload;
  logic             w_bdone, w_rdone;
  int               w_wi, w_ri;

  assign w_wload = (r_wst == W_IDLE);
  assign w_rload = (r_rst == R_IDLE);
  assign w_bdone = (r_wst == W_RESP) && m_bvalid && m_bready;
  assign w_rdone = (r_rst == R_DATA) && m_rvalid && m_rready
                   && m_rlast;
  assign w_wi    = int'(r_widx);
  assign w_ri    = int'(r_ridx);

  rr_arbiter #(.M_NUM(M_NUM), .PW(PW)) u_wr_arb (
    .i_req   (s_awvalid),
    .i_ptr   (r_wptr),
    .i_load  (w_wload),
    .o_grant (w_wgnt_arb),
    .o_idx   (w_widx_arb)
  );

  rr_arbiter #(.M_NUM(M_NUM), .PW(PW)) u_rd_arb (
    .i_req   (s_arvalid),
    .i_ptr   (r_rptr),
    .i_load  (w_rload),
    .o_grant (w_rgnt_arb),
    .o_idx   (w_ridx_arb)
  );

  // write FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_wst <= W_IDLE;
    else       r_wst <= w_wst_nxt;
  end

  // write FSM next state; W ends on wlast, len not counted
  always_comb begin
    w_wst_nxt = r_wst;
    unique case (r_wst)
      W_IDLE: if (|s_awvalid) w_wst_nxt = W_ADDR;
      W_ADDR: if (m_awvalid && m_awready) w_wst_nxt = W_DATA;
      W_DATA: if (m_wvalid && m_wready && m_wlast)
                w_wst_nxt = W_RESP;
      W_RESP: if (w_bdone) w_wst_nxt = W_IDLE;
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  // write grant held until B handshake, then pointer moves to it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wgnt <= '0;
      r_widx <= '0;
      r_wptr <= PW'(M_NUM - 1);
    end else if (w_wload && |s_awvalid) begin
      r_wgnt <= w_wgnt_arb;
      r_widx <= w_widx_arb;
    end else if (w_bdone) begin
      r_wgnt <= '0;
      r_wptr <= r_widx;
    end
  end

  // read FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rst <= R_IDLE;
    else       r_rst <= w_rst_nxt;
  end

  // read FSM next state
  always_comb begin
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE: if (|s_arvalid) w_rst_nxt = R_ADDR;
      R_ADDR: if (m_arvalid && m_arready) w_rst_nxt = R_DATA;
      R_DATA: if (w_rdone) w_rst_nxt = R_IDLE;
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  // read grant held until last R beat, then pointer moves to it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rgnt <= '0;
      r_ridx <= '0;
      r_rptr <= PW'(M_NUM - 1);
    end else if (w_rload && |s_arvalid) begin
      r_rgnt <= w_rgnt_arb;
      r_ridx <= w_ridx_arb;
    end else if (w_rdone) begin
      r_rgnt <= '0;
      r_rptr <= r_ridx;
    end
  end

  assign wr_grant = r_wgnt;
  assign rd_grant = r_rgnt;

  // write-side muxes; only the granted lane is ever non-zero
  always_comb begin
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awburst = BURST_FIXED;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bid     = '0;
    s_bresp   = {M_NUM{RESP_OKAY}};
    s_bvalid  = '0;
    unique case (r_wst)
      W_ADDR: begin
        m_awid    = s_awid[w_wi*ID_W +: ID_W];
        m_awaddr  = s_awaddr[w_wi*ADDR_W +: ADDR_W];
        m_awlen   = s_awlen[w_wi*8 +: 8];
        m_awburst = s_awburst[w_wi*2 +: 2];
        m_awvalid = s_awvalid[r_widx];
        s_awready[r_widx] = m_awready;
      end
      W_DATA: begin
        m_wdata  = s_wdata[w_wi*DATA_W +: DATA_W];
        m_wstrb  = s_wstrb[w_wi*SW +: SW];
        m_wlast  = s_wlast[r_widx];
        m_wvalid = s_wvalid[r_widx];
        s_wready[r_widx] = m_wready;
      end
      W_RESP: begin
        m_bready = s_bready[r_widx];
        s_bvalid[r_widx]          = m_bvalid;
        s_bid[w_wi*ID_W +: ID_W]  = m_bid;
        s_bresp[w_wi*2 +: 2]      = m_bresp;
      end
      default: ;
    endcase
  end

  // read-side muxes; only the granted lane is ever non-zero
  always_comb begin
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arburst = BURST_FIXED;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = {M_NUM{RESP_OKAY}};
    s_rlast   = '0;
    s_rvalid  = '0;
    unique case (r_rst)
      R_ADDR: begin
        m_arid    = s_arid[w_ri*ID_W +: ID_W];
        m_araddr  = s_araddr[w_ri*ADDR_W +: ADDR_W];
        m_arlen   = s_arlen[w_ri*8 +: 8];
        m_arburst = s_arburst[w_ri*2 +: 2];
        m_arvalid = s_arvalid[r_ridx];
        s_arready[r_ridx] = m_arready;
      end
      R_DATA: begin
        m_rready = s_rready[r_ridx];
        s_rvalid[r_ridx]              = m_rvalid;
        s_rlast[r_ridx]               = m_rlast;
        s_rid[w_ri*ID_W +: ID_W]      = m_rid;
        s_rdata[w_ri*DATA_W +: DATA_W] = m_rdata;
        s_rresp[w_ri*2 +: 2]          = m_rresp;
      end
      default: ;
    endcase
  end

endmodule
